mux_nto1_rr: RTL and testbench

Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshaking on every input and on the output. It replaces the purely combinational 8-to-1 word mux wherever several producers (register file read ports, ALU/immediate/memory result sources) must share one consumer. Two selection modes are supported:

- **Direct:** the channel is chosen by an explicit select input.
- **Round-robin:** the block arbitrates fairly among the valid channels.

The output is registered, so the block also serves as a one-stage pipeline register.

---
 rtl/mux_nto1_rr.sv | 89 ++++++++
 tb/tb_mux_nto1_rr.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_rr.sv
// N-channel registered selector, direct or round-robin grant, valid/ready on all sides; 1-cycle latency.
// Optional MUX_NTO1_XFER_COUNT_EN adds a saturating 16-bit output-transfer counter on port Count.
module mux_nto1_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SW    = $clog2(N)
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] X [N],
  input  logic [N-1:0]     XValid,
  output logic [N-1:0]     XReady,
  input  logic             Mode,
  input  logic [SW-1:0]    S,
  output logic [WIDTH-1:0] Y,
  output logic             YValid,
  input  logic             YReady,
  output logic [SW-1:0]    YSrc
`ifdef MUX_NTO1_XFER_COUNT_EN
  ,
  output logic [15:0]      Count
`endif
);

  logic          accept;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] ptr;
  int            idx;

  assign accept = !YValid || YReady;

  // Round-robin scans upward from the channel after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!Mode) begin
      if (int'(S) < N) begin
        if (XValid[S]) begin
          gnt_vld = 1'b1;
          gnt_idx = S;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!gnt_vld && XValid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(idx);
        end
      end
    end
  end

  always_comb begin
    XReady = '0;
    for (int i = 0; i < N; i++) begin
      XReady[i] = ResetN && accept && gnt_vld && (gnt_idx == SW'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      Y      <= '0;
      YValid <= 1'b0;
      YSrc   <= '0;
      ptr    <= SW'(N - 1);
    end else if (accept && gnt_vld) begin
      Y      <= X[gnt_idx];
      YSrc   <= gnt_idx;
      YValid <= 1'b1;
      ptr    <= gnt_idx;
    end else if (YValid && YReady) begin
      YValid <= 1'b0;
    end
  end

`ifdef MUX_NTO1_XFER_COUNT_EN
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      Count <= '0;
    end else if (YValid && YReady && (Count != 16'hFFFF)) begin
      Count <= Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr: reference model predicts grants and output words from the selection rules.
module tb_mux_nto1_rr;
  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int SW    = $clog2(N);

  logic             Clk = 1'b0;
  logic             ResetN;
  logic [WIDTH-1:0] X [N];
  logic [N-1:0]     XValid;
  logic [N-1:0]     XReady;
  logic             Mode;
  logic [SW-1:0]    S;
  logic [WIDTH-1:0] Y;
  logic             YValid;
  logic             YReady;
  logic [SW-1:0]    YSrc;
`ifdef MUX_NTO1_XFER_COUNT_EN
  logic [15:0]      Count;
`endif

  mux_nto1_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .Clk(Clk), .ResetN(ResetN), .X(X), .XValid(XValid), .XReady(XReady),
    .Mode(Mode), .S(S), .Y(Y), .YValid(YValid), .YReady(YReady), .YSrc(YSrc)
`ifdef MUX_NTO1_XFER_COUNT_EN
    , .Count(Count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [WIDTH-1:0] dat;
    int               src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant rule: direct select when valid, else first valid channel after the last grant.
  function automatic int ref_grant(input bit mode, input int s, input logic [N-1:0] v, input int last);
    if (!mode) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Reference model: checks the current state, then advances to the next edge.
  bit       m_yv = 1'b0;
  int       m_last = N - 1;
  bit       m_rst_prev = 1'b1;
  int       m_cnt = 0;
  always @(negedge Clk) begin
    int g;
    bit acc;
    logic [N-1:0] exp_rdy;
    if (!done) begin
      check("yvalid", YValid, m_yv);
      if (m_rst_prev) begin
        check("reset_y", Y, 0);
        check("reset_ysrc", YSrc, 0);
      end
`ifdef MUX_NTO1_XFER_COUNT_EN
      check("count", Count, m_cnt);
`endif
      acc = !m_yv || YReady;
      g = ref_grant(Mode, int'(S), XValid, m_last);
      exp_rdy = '0;
      if (ResetN && acc && g >= 0) exp_rdy[g] = 1'b1;
      check("xready", XReady, exp_rdy);
      if (!ResetN) begin
        m_yv = 1'b0;
        m_last = N - 1;
        m_cnt = 0;
        exp_q.delete();
      end else begin
        if (m_yv && YReady && m_cnt != 16'hFFFF) m_cnt++;
        if (acc && g >= 0) begin
          exp_q.push_back('{dat: X[g], src: g});
          m_yv = 1'b1;
          m_last = g;
        end else if (m_yv && YReady) begin
          m_yv = 1'b0;
        end
      end
      m_rst_prev = !ResetN;
    end
  end

  // Monitor: every consumed output word must match the oldest predicted one.
  always @(negedge Clk) begin
    exp_t e;
    if (!done && ResetN && YValid && YReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h src %0d with nothing expected", Y, YSrc);
      end else begin
        e = exp_q.pop_front();
        check("y_data", Y, e.dat);
        check("y_src", YSrc, e.src);
      end
    end
  end

  task automatic step(input bit rst_n, input bit mode, input int s, input logic [N-1:0] v, input bit yr);
    @(posedge Clk);
    #1;
    ResetN = rst_n;
    Mode   = mode;
    S      = SW'(s);
    XValid = v;
    YReady = yr;
  endtask

  initial begin
    ResetN = 1'b0;
    Mode   = 1'b1;
    S      = '0;
    XValid = '1;
    YReady = 1'b1;
    for (int i = 0; i < N; i++) X[i] = WIDTH'(16'h1000 + i);
    step(0, 1, 0, '1, 1);
    step(1, 1, 0, '1, 1);
    step(1, 1, 0, '1, 1);
    // Direct sweep, then an invalid selected channel.
    for (int s = 0; s < N; s++) step(1, 0, s, '1, 1);
    step(1, 0, 3, 8'b1111_0111, 1);
    step(1, 0, 3, 8'b1111_0111, 1);
    // Round-robin over a sparse set.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 8'b1010_0101, 1);
    // Back-pressure for 3 cycles, release, then a reset while stalled.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'b1010_0101, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'b1010_0101, 1);
    step(1, 1, 0, '1, 0);
    step(1, 1, 0, '1, 0);
    step(0, 1, 0, '1, 0);
    step(1, 1, 0, '1, 1);
    // Direct grant on 6, then round-robin wraps to 1 then 6.
    step(1, 0, 6, '1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8'b0100_0010, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), 1'($urandom), $urandom_range(0, N - 1),
           N'($urandom), ($urandom_range(0, 3) != 0));
      for (int c = 0; c < N; c++) X[c] = WIDTH'($urandom);
    end
    for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 1);
    @(negedge Clk);
    #1;
    done = 1'b1;
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
